regfile_wb_arbiter: RTL and testbench

Write-back arbiter and scoreboard for the 32-entry integer register file. It shares the register file's single write port between the execute unit (EXU) and the load/store unit (LSU) using round-robin arbitration, and it registers the winning write before it reaches the port. It also keeps one pending bit per architectural register, so the issue stage can stall on RAW and WAW hazards. It sits between the EXU/LSU write-back outputs, the issue stage and the register file write port.

---
 rtl/regfile_wb_arbiter.sv | 109 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and pending-write scoreboard for the 32-entry integer register file.
// EXU and LSU share one registered write port under round-robin; issue stalls on WAW.
module regfile_wb_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exu_valid,
  output logic             exu_ready,
  input  logic [4:0]       exu_rd,
  input  logic [WIDTH-1:0] exu_data,
  input  logic             lsu_valid,
  output logic             lsu_ready,
  input  logic [4:0]       lsu_rd,
  input  logic [WIDTH-1:0] lsu_data,
  output logic             rf_wen,
  output logic [4:0]       rf_rd_addr,
  output logic [WIDTH-1:0] rf_rd_data,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  output logic             issue_ready,
  input  logic [4:0]       rs1_addr,
  output logic             rs1_busy,
  input  logic [4:0]       rs2_addr,
  output logic             rs2_busy,
  output logic             sb_err
);

  logic             last_lsu_q, last_lsu_d;
  logic             wen_q, wen_d;
  logic [4:0]       addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [31:0]      pending_q, pending_d;
  logic             err_q, err_d;

  logic             xfer;
  logic [4:0]       win_rd;
  logic [WIDTH-1:0] win_data;
  logic             issue_xfer;

  // last_lsu_q = 1 means the LSU won the most recent transfer, so the EXU wins a tie.
  always_comb begin
    exu_ready = exu_valid & (~lsu_valid | last_lsu_q);
    lsu_ready = lsu_valid & (~exu_valid | ~last_lsu_q);
    xfer      = exu_ready | lsu_ready;
    win_rd    = exu_ready ? exu_rd : lsu_rd;
    win_data  = exu_ready ? exu_data : lsu_data;
  end

  always_comb begin
    issue_ready = (issue_rd == 5'd0) | ~pending_q[issue_rd];
    issue_xfer  = issue_valid & issue_ready;
    rs1_busy    = pending_q[rs1_addr];
    rs2_busy    = pending_q[rs2_addr];
  end

  always_comb begin
    last_lsu_d = last_lsu_q;
    wen_d      = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    err_d      = err_q;
    if (xfer) begin
      last_lsu_d = lsu_ready;
      wen_d      = (win_rd != 5'd0);
      addr_d     = win_rd;
      data_d     = win_data;
      if ((win_rd != 5'd0) && !pending_q[win_rd]) begin
        err_d = 1'b1;
      end
    end
  end

  // Clear retires the write emitted this cycle; set and clear never collide on one register.
  always_comb begin
    pending_d = pending_q;
    if (wen_q) begin
      pending_d[addr_q] = 1'b0;
    end
    if (issue_xfer && (issue_rd != 5'd0)) begin
      pending_d[issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_lsu_q <= 1'b1;
      wen_q      <= 1'b0;
      addr_q     <= 5'd0;
      data_q     <= '0;
      pending_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      last_lsu_q <= last_lsu_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      pending_q  <= pending_d;
      err_q      <= err_d;
    end
  end

  assign rf_wen     = wen_q;
  assign rf_rd_addr = addr_q;
  assign rf_rd_data = data_q;
  assign sb_err     = err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a per-register pending model.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        exu_valid, lsu_valid, issue_valid;
  logic        exu_ready, lsu_ready, issue_ready;
  logic [4:0]  exu_rd, lsu_rd, issue_rd, rs1_addr, rs2_addr, rf_rd_addr;
  logic [31:0] exu_data, lsu_data, rf_rd_data;
  logic        rf_wen, rs1_busy, rs2_busy, sb_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .exu_valid  (exu_valid),
    .exu_ready  (exu_ready),
    .exu_rd     (exu_rd),
    .exu_data   (exu_data),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_rd     (lsu_rd),
    .lsu_data   (lsu_data),
    .rf_wen     (rf_wen),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .issue_ready(issue_ready),
    .rs1_addr   (rs1_addr),
    .rs1_busy   (rs1_busy),
    .rs2_addr   (rs2_addr),
    .rs2_busy   (rs2_busy),
    .sb_err     (sb_err)
  );

  typedef struct {
    logic        ev;  logic [4:0] erd; logic [31:0] ed;
    logic        lv;  logic [4:0] lrd; logic [31:0] ld;
    logic        iv;  logic [4:0] ird;
    logic [4:0]  r1;  logic [4:0] r2;
    logic        x_er, x_lr, x_ir, x_wen;
    logic [4:0]  x_addr; logic [31:0] x_data;
    logic        x_b1, x_b2, x_err;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ev, input logic [4:0] erd, input logic [31:0] ed,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic iv, input logic [4:0] ird,
                       input logic [4:0] r1, input logic [4:0] r2);
    exu_valid = ev; exu_rd = erd; exu_data = ed;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    issue_valid = iv; issue_rd = ird;
    rs1_addr = r1; rs2_addr = r2;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Random-phase reference model: a pending bit per register, plus the write due next cycle.
  bit          m_pend[32];
  bit          m_last_lsu;
  bit          m_wen;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_err;
  bit          e_req, l_req;
  logic [4:0]  e_rd, l_rd;
  logic [31:0] e_dat, l_dat;

  function automatic logic [4:0] pick_rd();
    logic [4:0] r;
    r = 5'($urandom_range(0, 31));
    if ($urandom_range(0, 3) != 0) begin
      for (int k = 0; k < 8; k++) begin
        if (m_pend[r]) break;
        r = 5'($urandom_range(1, 31));
      end
    end
    return r;
  endfunction

  initial begin
    rst = 1'b0;
    idle();

    //            ev erd  ed            lv lrd  ld            iv ird  r1 r2  er lr ir wen addr data          b1 b2 err
    tbl[0]  = '{1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,       1'b1,5'd5,5'd5,5'd0, 1'b0,1'b0,1'b1,1'b0,5'd0,32'h0,        1'b0,1'b0,1'b0};
    tbl[1]  = '{1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,       1'b1,5'd1,5'd5,5'd1, 1'b0,1'b0,1'b1,1'b0,5'd0,32'h0,        1'b1,1'b0,1'b0};
    tbl[2]  = '{1'b1,5'd5,32'hDEADBEEF,1'b0,5'd0,32'h0,       1'b1,5'd2,5'd5,5'd2, 1'b1,1'b0,1'b1,1'b0,5'd0,32'h0,        1'b1,1'b0,1'b0};
    tbl[3]  = '{1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,       1'b1,5'd5,5'd5,5'd2, 1'b0,1'b0,1'b0,1'b1,5'd5,32'hDEADBEEF, 1'b1,1'b1,1'b0};
    tbl[4]  = '{1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,       1'b1,5'd5,5'd5,5'd1, 1'b0,1'b0,1'b1,1'b0,5'd5,32'hDEADBEEF, 1'b0,1'b1,1'b0};
    tbl[5]  = '{1'b1,5'd0,32'h1234,    1'b0,5'd0,32'h0,       1'b0,5'd0,5'd0,5'd5, 1'b1,1'b0,1'b1,1'b0,5'd5,32'hDEADBEEF, 1'b0,1'b1,1'b0};
    tbl[6]  = '{1'b0,5'd0,32'h0,       1'b1,5'd9,32'hCAFE0009,1'b0,5'd0,5'd9,5'd0, 1'b0,1'b1,1'b1,1'b0,5'd0,32'h1234,     1'b0,1'b0,1'b0};
    tbl[7]  = '{1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,       1'b0,5'd9,5'd9,5'd1, 1'b0,1'b0,1'b1,1'b1,5'd9,32'hCAFE0009, 1'b0,1'b1,1'b1};
    tbl[8]  = '{1'b1,5'd1,32'h11111111,1'b0,5'd0,32'h0,       1'b0,5'd0,5'd1,5'd2, 1'b1,1'b0,1'b1,1'b0,5'd9,32'hCAFE0009, 1'b1,1'b1,1'b1};
    tbl[9]  = '{1'b0,5'd0,32'h0,       1'b1,5'd2,32'h22222222,1'b0,5'd0,5'd1,5'd2, 1'b0,1'b1,1'b1,1'b1,5'd1,32'h11111111, 1'b1,1'b1,1'b1};
    tbl[10] = '{1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,       1'b0,5'd0,5'd1,5'd2, 1'b0,1'b0,1'b1,1'b1,5'd2,32'h22222222, 1'b0,1'b1,1'b1};
    tbl[11] = '{1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,       1'b0,5'd0,5'd2,5'd5, 1'b0,1'b0,1'b1,1'b0,5'd2,32'h22222222, 1'b0,1'b1,1'b1};

    // Reset state
    do_reset();
    #1;
    chk("reset rf_wen", {31'd0, rf_wen}, 32'd0);
    chk("reset rf_rd_addr", {27'd0, rf_rd_addr}, 32'd0);
    chk("reset rf_rd_data", rf_rd_data, 32'd0);
    chk("reset sb_err", {31'd0, sb_err}, 32'd0);

    // Directed vector table, one row per cycle
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(tbl[i].ev, tbl[i].erd, tbl[i].ed, tbl[i].lv, tbl[i].lrd, tbl[i].ld,
            tbl[i].iv, tbl[i].ird, tbl[i].r1, tbl[i].r2);
      #1;
      chk($sformatf("row%0d exu_ready", i), {31'd0, exu_ready}, {31'd0, tbl[i].x_er});
      chk($sformatf("row%0d lsu_ready", i), {31'd0, lsu_ready}, {31'd0, tbl[i].x_lr});
      chk($sformatf("row%0d issue_ready", i), {31'd0, issue_ready}, {31'd0, tbl[i].x_ir});
      chk($sformatf("row%0d rf_wen", i), {31'd0, rf_wen}, {31'd0, tbl[i].x_wen});
      chk($sformatf("row%0d rf_rd_addr", i), {27'd0, rf_rd_addr}, {27'd0, tbl[i].x_addr});
      chk($sformatf("row%0d rf_rd_data", i), rf_rd_data, tbl[i].x_data);
      chk($sformatf("row%0d rs1_busy", i), {31'd0, rs1_busy}, {31'd0, tbl[i].x_b1});
      chk($sformatf("row%0d rs2_busy", i), {31'd0, rs2_busy}, {31'd0, tbl[i].x_b2});
      chk($sformatf("row%0d sb_err", i), {31'd0, sb_err}, {31'd0, tbl[i].x_err});
    end

    // Reset mid-run with a write registered but not yet consumed
    @(negedge clk);
    drive(1'b1, 5'd5, 32'hA5A5A5A5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    idle();
    #1;
    chk("midreset pre rf_wen", {31'd0, rf_wen}, 32'd1);
    rst = 1'b0;
    #1;
    chk("midreset rf_wen", {31'd0, rf_wen}, 32'd0);
    chk("midreset rf_rd_addr", {27'd0, rf_rd_addr}, 32'd0);
    chk("midreset rf_rd_data", rf_rd_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int r = 0; r < 32; r++) begin
      rs1_addr = 5'(r);
      #1;
      chk($sformatf("midreset rs1_busy[%0d]", r), {31'd0, rs1_busy}, 32'd0);
    end
    chk("midreset sb_err", {31'd0, sb_err}, 32'd0);

    // Conflict from reset: grants alternate EXU, LSU, EXU, LSU
    for (int r = 1; r <= 4; r++) begin
      @(negedge clk);
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(r), 5'd0, 5'd0);
      #1;
      chk($sformatf("conflict issue %0d ready", r), {31'd0, issue_ready}, 32'd1);
    end
    begin
      logic [4:0] eq[2];
      logic [4:0] lq[2];
      int ei, li;
      eq[0] = 5'd1; eq[1] = 5'd3; lq[0] = 5'd2; lq[1] = 5'd4;
      ei = 0; li = 0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        drive(ei < 2, eq[ei % 2], {4{3'd0, eq[ei % 2]}}, li < 2, lq[li % 2], {4{3'd0, lq[li % 2]}},
              1'b0, 5'd0, 5'd0, 5'd0);
        #1;
        chk($sformatf("conflict c%0d exu_ready", c), {31'd0, exu_ready}, {31'd0, c % 2 == 0});
        chk($sformatf("conflict c%0d lsu_ready", c), {31'd0, lsu_ready}, {31'd0, c % 2 == 1});
        if (c > 0) begin
          chk($sformatf("conflict c%0d rf_wen", c), {31'd0, rf_wen}, 32'd1);
          chk($sformatf("conflict c%0d rf_rd_addr", c), {27'd0, rf_rd_addr}, 32'(c));
          chk($sformatf("conflict c%0d rf_rd_data", c), rf_rd_data, {4{8'(c)}});
        end
        if (c % 2 == 0) ei++;
        else li++;
      end
      @(negedge clk);
      idle();
      #1;
      chk("conflict tail rf_wen", {31'd0, rf_wen}, 32'd1);
      chk("conflict tail rf_rd_addr", {27'd0, rf_rd_addr}, 32'd4);
      chk("conflict sb_err", {31'd0, sb_err}, 32'd0);
    end

    // Randomized traffic against the model
    do_reset();
    foreach (m_pend[k]) m_pend[k] = 1'b0;
    m_last_lsu = 1'b1; m_wen = 1'b0; m_addr = 5'd0; m_data = 32'd0; m_err = 1'b0;
    e_req = 1'b0; l_req = 1'b0; e_rd = 5'd0; l_rd = 5'd0; e_dat = 32'd0; l_dat = 32'd0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit any, win_lsu, i_ok;
      logic [4:0] w_rd;
      logic [4:0] i_rd;
      logic i_v;
      @(negedge clk);
      if (!e_req && $urandom_range(0, 2) != 0) begin
        e_req = 1'b1; e_rd = pick_rd(); e_dat = $urandom;
      end
      if (!l_req && $urandom_range(0, 2) != 0) begin
        l_req = 1'b1; l_rd = pick_rd(); l_dat = $urandom;
      end
      i_v  = 1'($urandom_range(0, 1));
      i_rd = 5'($urandom_range(0, 31));
      drive(e_req, e_rd, e_dat, l_req, l_rd, l_dat, i_v, i_rd,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      any     = e_req | l_req;
      win_lsu = (e_req && l_req) ? !m_last_lsu : l_req;
      i_ok    = (i_rd == 5'd0) || !m_pend[i_rd];
      #1;
      chk($sformatf("rand%0d exu_ready", cyc), {31'd0, exu_ready}, {31'd0, any && !win_lsu});
      chk($sformatf("rand%0d lsu_ready", cyc), {31'd0, lsu_ready}, {31'd0, any && win_lsu});
      chk($sformatf("rand%0d issue_ready", cyc), {31'd0, issue_ready}, {31'd0, i_ok});
      chk($sformatf("rand%0d rf_wen", cyc), {31'd0, rf_wen}, {31'd0, m_wen});
      chk($sformatf("rand%0d rf_rd_addr", cyc), {27'd0, rf_rd_addr}, {27'd0, m_addr});
      chk($sformatf("rand%0d rf_rd_data", cyc), rf_rd_data, m_data);
      chk($sformatf("rand%0d rs1_busy", cyc), {31'd0, rs1_busy}, {31'd0, m_pend[rs1_addr]});
      chk($sformatf("rand%0d rs2_busy", cyc), {31'd0, rs2_busy}, {31'd0, m_pend[rs2_addr]});
      chk($sformatf("rand%0d sb_err", cyc), {31'd0, sb_err}, {31'd0, m_err});
      // Advance the model to the state after the coming clock edge
      w_rd = win_lsu ? l_rd : e_rd;
      if (m_wen) m_pend[m_addr] = 1'b0;
      if (any) begin
        if (w_rd != 5'd0 && !m_pend[w_rd]) m_err = 1'b1;
        m_wen      = (w_rd != 5'd0);
        m_addr     = w_rd;
        m_data     = win_lsu ? l_dat : e_dat;
        m_last_lsu = win_lsu;
        if (win_lsu) l_req = 1'b0;
        else e_req = 1'b0;
      end else begin
        m_wen = 1'b0;
      end
      if (i_v && i_ok && i_rd != 5'd0) m_pend[i_rd] = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
